// File: rtl/pipe_ctrl_if.sv
// Control-unit bundle: hazard inputs from the datapath, stall/bubble and status outputs back to it.
interface pipe_ctrl_if #(parameter int CNT_W = 32);
    logic [3:0]       D_icode_i;
    logic [3:0]       E_icode_i;
    logic [3:0]       M_icode_i;
    logic [3:0]       E_dstM_i;
    logic [3:0]       d_srcA_i;
    logic [3:0]       d_srcB_i;
    logic             e_Cnd_i;
    logic [2:0]       m_stat_i;
    logic [2:0]       W_stat_i;
    logic             freeze_req_i;
    logic             cnt_clr_i;
    logic             F_stall_o;
    logic             D_stall_o;
    logic             D_bubble_o;
    logic             E_bubble_o;
    logic             M_bubble_o;
    logic             W_stall_o;
    logic             set_cc_o;
    logic             freeze_ack_o;
    logic             halted_o;
    logic [CNT_W-1:0] cyc_cnt_o;
    logic [CNT_W-1:0] lu_cnt_o;
    logic [CNT_W-1:0] mispred_cnt_o;
    logic [CNT_W-1:0] ret_cnt_o;

    modport master (
        output D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i, freeze_req_i, cnt_clr_i,
        input  F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
               set_cc_o, freeze_ack_o, halted_o, cyc_cnt_o, lu_cnt_o, mispred_cnt_o, ret_cnt_o
    );

    modport slave (
        input  D_icode_i, E_icode_i, M_icode_i, E_dstM_i, d_srcA_i, d_srcB_i,
               e_Cnd_i, m_stat_i, W_stat_i, freeze_req_i, cnt_clr_i,
        output F_stall_o, D_stall_o, D_bubble_o, E_bubble_o, M_bubble_o, W_stall_o,
               set_cc_o, freeze_ack_o, halted_o, cyc_cnt_o, lu_cnt_o, mispred_cnt_o, ret_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Y86-64 pipeline control: combinational stall/bubble generation plus run/drain/frozen/stopped FSM.
// Controls have zero latency; ack/halted/counters are registered. Freeze waits for hazards to clear.
module pipe_ctrl #(
    parameter int CNT_W        = 32,
    parameter int DRAIN_CYCLES = 3
) (
    input logic         clk_i,
    input logic         rst_i,
    pipe_ctrl_if.slave  pc
);
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] R_NONE   = 4'hF;
    localparam int         DW       = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
    localparam logic [DW-1:0] DRAIN_LAST = DW'(DRAIN_CYCLES - 1);

    typedef enum logic [1:0] {RUN, DRAIN, FROZEN, STOPPED} state_t;

    state_t        state, state_nxt;
    logic [DW-1:0] drain_cnt, drain_cnt_nxt;
    logic          lu, mp, rt, xm, xw;

    function automatic logic is_exc(input logic [2:0] s);
        return (s == 3'd2) || (s == 3'd3) || (s == 3'd4);
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v, input logic en);
        return (en && (v != '1)) ? v + 1'b1 : v;
    endfunction

    always_comb begin
        lu = ((pc.E_icode_i == I_MRMOVQ) || (pc.E_icode_i == I_POPQ)) &&
             (pc.E_dstM_i != R_NONE) &&
             ((pc.E_dstM_i == pc.d_srcA_i) || (pc.E_dstM_i == pc.d_srcB_i));
        mp = (pc.E_icode_i == I_JXX) && !pc.e_Cnd_i;
        rt = (pc.D_icode_i == I_RET) || (pc.E_icode_i == I_RET) || (pc.M_icode_i == I_RET);
        xm = is_exc(pc.m_stat_i);
        xw = is_exc(pc.W_stat_i);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state           <= RUN;
            drain_cnt       <= '0;
            pc.freeze_ack_o <= 1'b0;
            pc.halted_o     <= 1'b0;
        end else begin
            state           <= state_nxt;
            drain_cnt       <= drain_cnt_nxt;
            pc.freeze_ack_o <= (state_nxt == FROZEN);
            pc.halted_o     <= (state_nxt == STOPPED);
        end
    end

    always_comb begin
        state_nxt     = state;
        drain_cnt_nxt = drain_cnt;
        pc.F_stall_o  = lu | rt;
        pc.D_stall_o  = lu;
        pc.D_bubble_o = mp | (rt & ~lu);
        pc.E_bubble_o = mp | lu;
        pc.M_bubble_o = xm | xw;
        pc.W_stall_o  = xw;
        pc.set_cc_o   = (pc.E_icode_i == I_OPQ) & ~xm & ~xw;

        case (state)
            RUN: begin
                if (xw) begin
                    state_nxt = STOPPED;
                end else if (pc.freeze_req_i && !lu && !mp && !rt) begin
                    state_nxt     = DRAIN;
                    drain_cnt_nxt = '0;
                end
            end
            DRAIN: begin
                pc.F_stall_o  = 1'b1;
                pc.D_stall_o  = 1'b1;
                pc.E_bubble_o = 1'b1;
                if (xw) begin
                    state_nxt = STOPPED;
                end else if (!pc.freeze_req_i) begin
                    state_nxt = RUN;
                end else if (drain_cnt == DRAIN_LAST) begin
                    state_nxt = FROZEN;
                end else begin
                    drain_cnt_nxt = drain_cnt + 1'b1;
                end
            end
            FROZEN: begin
                pc.F_stall_o  = 1'b1;
                pc.D_stall_o  = 1'b1;
                pc.E_bubble_o = 1'b1;
                if (!pc.freeze_req_i) state_nxt = RUN;
            end
            default: begin
                pc.F_stall_o  = 1'b1;
                pc.D_stall_o  = 1'b1;
                pc.W_stall_o  = 1'b1;
                pc.D_bubble_o = 1'b1;
                pc.E_bubble_o = 1'b1;
                pc.M_bubble_o = 1'b1;
                pc.set_cc_o   = 1'b0;
            end
        endcase

        // Reset flushes the pipe with bubbles rather than holding stale registers.
        if (rst_i) begin
            pc.F_stall_o  = 1'b0;
            pc.D_stall_o  = 1'b0;
            pc.W_stall_o  = 1'b0;
            pc.D_bubble_o = 1'b1;
            pc.E_bubble_o = 1'b1;
            pc.M_bubble_o = 1'b1;
            pc.set_cc_o   = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || pc.cnt_clr_i) begin
            pc.cyc_cnt_o     <= '0;
            pc.lu_cnt_o      <= '0;
            pc.mispred_cnt_o <= '0;
            pc.ret_cnt_o     <= '0;
        end else if (state == RUN) begin
            pc.cyc_cnt_o     <= sat_inc(pc.cyc_cnt_o, 1'b1);
            pc.lu_cnt_o      <= sat_inc(pc.lu_cnt_o, lu);
            pc.mispred_cnt_o <= sat_inc(pc.mispred_cnt_o, mp);
            pc.ret_cnt_o     <= sat_inc(pc.ret_cnt_o, rt & ~lu);
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl with 4-bit counters: reference model feeds an expectation queue each cycle.
module tb_pipe_ctrl;
    localparam int CW = 4;

    logic clk_i = 1'b0;
    logic rst_i;
    always #5 clk_i = ~clk_i;

    pipe_ctrl_if #(.CNT_W(CW)) bus ();
    pipe_ctrl #(.CNT_W(CW), .DRAIN_CYCLES(3)) dut (.clk_i(clk_i), .rst_i(rst_i), .pc(bus));

    typedef struct packed {
        logic [6:0]    ctrl;   // {F_stall, D_stall, D_bubble, E_bubble, M_bubble, W_stall, set_cc}
        logic          ack;
        logic          halt;
        logic [CW-1:0] cyc, lu, mp, rt;
    } exp_t;

    typedef enum int {M_RUN, M_DRAIN, M_FROZEN, M_STOP} mst_t;

    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;
    mst_t          ms;
    int            mcnt;
    logic [CW-1:0] mc_cyc, mc_lu, mc_mp, mc_rt;
    logic          m_ack, m_halt;
    logic [3:0]    ic_tab[6] = '{4'h1, 4'h5, 4'h6, 4'h7, 4'h9, 4'hB};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_chk++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s t=%0t got %0h expected %0h", tag, $time, obs, exp_v);
        end
    endtask

    function automatic logic exc(input logic [2:0] s);
        return s inside {3'd2, 3'd3, 3'd4};
    endfunction

    function automatic logic [CW-1:0] bump(input logic [CW-1:0] v, input logic en);
        if (en && int'(v) < (1 << CW) - 1) return v + 1'b1;
        return v;
    endfunction

    task automatic hazards(output logic lu, output logic mp, output logic rt,
                           output logic xm, output logic xw);
        lu = (bus.E_icode_i inside {4'h5, 4'hB}) && bus.E_dstM_i != 4'hF &&
             (bus.E_dstM_i == bus.d_srcA_i || bus.E_dstM_i == bus.d_srcB_i);
        mp = bus.E_icode_i == 4'h7 && !bus.e_Cnd_i;
        rt = bus.D_icode_i == 4'h9 || bus.E_icode_i == 4'h9 || bus.M_icode_i == 4'h9;
        xm = exc(bus.m_stat_i);
        xw = exc(bus.W_stat_i);
    endtask

    task automatic model_out(output exp_t e);
        logic lu, mp, rt, xm, xw, cc;
        hazards(lu, mp, rt, xm, xw);
        cc = bus.E_icode_i == 4'h6 && !xm && !xw;
        if (rst_i)                 e.ctrl = 7'b0011100;
        else if (ms == M_STOP)     e.ctrl = 7'b1111110;
        else if (ms == M_RUN)      e.ctrl = {lu | rt, lu, mp | (rt & !lu), mp | lu, xm | xw, xw, cc};
        else                       e.ctrl = {1'b1, 1'b1, mp | (rt & !lu), 1'b1, xm | xw, xw, cc};
        e.ack  = m_ack;
        e.halt = m_halt;
        e.cyc  = mc_cyc;
        e.lu   = mc_lu;
        e.mp   = mc_mp;
        e.rt   = mc_rt;
    endtask

    task automatic model_reset();
        ms = M_RUN; mcnt = 0; m_ack = 0; m_halt = 0;
        mc_cyc = '0; mc_lu = '0; mc_mp = '0; mc_rt = '0;
    endtask

    task automatic model_step();
        logic lu, mp, rt, xm, xw;
        mst_t nx;
        hazards(lu, mp, rt, xm, xw);
        if (rst_i) begin
            model_reset();
            return;
        end
        if (bus.cnt_clr_i) begin
            mc_cyc = '0; mc_lu = '0; mc_mp = '0; mc_rt = '0;
        end else if (ms == M_RUN) begin
            mc_cyc = bump(mc_cyc, 1'b1);
            mc_lu  = bump(mc_lu, lu);
            mc_mp  = bump(mc_mp, mp);
            mc_rt  = bump(mc_rt, rt && !lu);
        end
        nx = ms;
        case (ms)
            M_RUN:    if (xw) nx = M_STOP;
                      else if (bus.freeze_req_i && !lu && !mp && !rt) begin nx = M_DRAIN; mcnt = 0; end
            M_DRAIN:  if (xw) nx = M_STOP;
                      else if (!bus.freeze_req_i) nx = M_RUN;
                      else if (mcnt == 2) nx = M_FROZEN;
                      else mcnt++;
            M_FROZEN: if (!bus.freeze_req_i) nx = M_RUN;
            default:  nx = M_STOP;
        endcase
        ms     = nx;
        m_ack  = (nx == M_FROZEN);
        m_halt = (nx == M_STOP);
    endtask

    // One clock: push expectation, compare mid-cycle, advance model on the edge.
    task automatic cyc();
        exp_t e, g;
        model_out(e);
        exp_q.push_back(e);
        #2;
        if (exp_q.size() == 0) begin
            n_chk++; n_err++;
            $display("FAIL sb_empty t=%0t got 0 expected 1", $time);
        end else begin
            g = exp_q.pop_front();
            check("ctrl", {bus.F_stall_o, bus.D_stall_o, bus.D_bubble_o, bus.E_bubble_o,
                           bus.M_bubble_o, bus.W_stall_o, bus.set_cc_o}, g.ctrl);
            check("ack",  bus.freeze_ack_o, g.ack);
            check("halt", bus.halted_o, g.halt);
            check("cyc",  bus.cyc_cnt_o, g.cyc);
            check("lu",   bus.lu_cnt_o, g.lu);
            check("mp",   bus.mispred_cnt_o, g.mp);
            check("rt",   bus.ret_cnt_o, g.rt);
        end
        @(posedge clk_i);
        model_step();
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.D_icode_i = 4'h1; bus.E_icode_i = 4'h1; bus.M_icode_i = 4'h1;
        bus.E_dstM_i = 4'hF; bus.d_srcA_i = 4'hF; bus.d_srcB_i = 4'hF;
        bus.e_Cnd_i = 1'b1; bus.m_stat_i = 3'd1; bus.W_stat_i = 3'd1;
        bus.freeze_req_i = 1'b0; bus.cnt_clr_i = 1'b0;
    endtask

    task automatic set_lu();
        bus.E_icode_i = 4'h5; bus.E_dstM_i = 4'h3; bus.d_srcA_i = 4'h3;
    endtask

    initial begin
        idle();
        rst_i = 1'b1;
        @(negedge clk_i); @(negedge clk_i);
        model_reset();
        cyc(); cyc();
        rst_i = 1'b0;

        // load/use, then dstM = none, then popq via srcB
        set_lu(); repeat (3) cyc();
        bus.E_dstM_i = 4'hF; cyc();
        bus.E_icode_i = 4'hB; bus.E_dstM_i = 4'h7; bus.d_srcA_i = 4'h2; bus.d_srcB_i = 4'h7; cyc();
        check("lu_cnt4", bus.lu_cnt_o, 4);
        idle();

        // mispredict, then taken branch
        bus.E_icode_i = 4'h7; bus.e_Cnd_i = 1'b0; cyc();
        check("mp_cnt1", bus.mispred_cnt_o, 1);
        bus.e_Cnd_i = 1'b1; cyc();
        idle();

        // RET walking D -> E -> M, then RET with load/use
        bus.cnt_clr_i = 1'b1; cyc(); bus.cnt_clr_i = 1'b0;
        bus.D_icode_i = 4'h9; cyc();
        bus.D_icode_i = 4'h1; bus.E_icode_i = 4'h9; cyc();
        bus.E_icode_i = 4'h1; bus.M_icode_i = 4'h9; cyc();
        check("rt_cnt3", bus.ret_cnt_o, 3);
        set_lu(); bus.D_icode_i = 4'h9; cyc();
        idle();

        // OPq set_cc, suppressed by memory / writeback exception
        bus.E_icode_i = 4'h6; cyc();
        bus.m_stat_i = 3'd3; cyc();
        bus.m_stat_i = 3'd4; cyc();
        idle();

        // freeze: ack after the fourth edge, release drops ack next edge
        bus.freeze_req_i = 1'b1; repeat (4) cyc();
        check("ack_e4", bus.freeze_ack_o, 1);
        bus.D_icode_i = 4'h9; cyc();
        bus.D_icode_i = 4'h1; repeat (2) cyc();
        bus.freeze_req_i = 1'b0; cyc();
        check("ack_drop", bus.freeze_ack_o, 0);
        cyc();

        // freeze during mispredict waits; abort mid-drain
        bus.freeze_req_i = 1'b1; bus.E_icode_i = 4'h7; bus.e_Cnd_i = 1'b0; repeat (2) cyc();
        bus.E_icode_i = 4'h1; repeat (2) cyc();
        bus.freeze_req_i = 1'b0; repeat (2) cyc();

        // reset from FROZEN
        bus.freeze_req_i = 1'b1; repeat (5) cyc();
        rst_i = 1'b1; cyc(); rst_i = 1'b0; cyc();
        idle();

        // saturation and clear-wins
        bus.cnt_clr_i = 1'b1; cyc(); bus.cnt_clr_i = 1'b0;
        set_lu(); repeat (20) cyc();
        check("lu_sat", bus.lu_cnt_o, 15);
        bus.cnt_clr_i = 1'b1; cyc(); bus.cnt_clr_i = 1'b0;
        check("lu_clr", bus.lu_cnt_o, 0);
        cyc();
        idle();

        // writeback exception stops the core; only reset recovers
        bus.W_stat_i = 3'd3; cyc();
        check("halted", bus.halted_o, 1);
        bus.W_stat_i = 3'd1; bus.freeze_req_i = 1'b1; set_lu(); repeat (3) cyc();
        idle();
        rst_i = 1'b1; cyc(); rst_i = 1'b0; cyc();
        check("unhalted", bus.halted_o, 0);

        // exception while draining
        bus.freeze_req_i = 1'b1; repeat (2) cyc();
        bus.W_stat_i = 3'd2; cyc();
        idle(); repeat (2) cyc();
        rst_i = 1'b1; cyc(); rst_i = 1'b0;

        // random traffic
        for (int i = 0; i < 400; i++) begin
            bus.D_icode_i    = ic_tab[$urandom_range(5, 0)];
            bus.E_icode_i    = ic_tab[$urandom_range(5, 0)];
            bus.M_icode_i    = ic_tab[$urandom_range(5, 0)];
            bus.E_dstM_i     = 4'($urandom_range(15, 12));
            bus.d_srcA_i     = 4'($urandom_range(15, 12));
            bus.d_srcB_i     = 4'($urandom_range(15, 12));
            bus.e_Cnd_i      = 1'($urandom_range(1, 0));
            bus.m_stat_i     = ($urandom_range(7, 0) == 0) ? 3'($urandom_range(4, 2)) : 3'd1;
            bus.W_stat_i     = ($urandom_range(29, 0) == 0) ? 3'($urandom_range(4, 2)) : 3'd1;
            bus.freeze_req_i = ($urandom_range(3, 0) != 0);
            bus.cnt_clr_i    = ($urandom_range(31, 0) == 0);
            rst_i            = ($urandom_range(24, 0) == 0);
            cyc();
        end
        rst_i = 1'b0;

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline control unit for the 5-stage Y86-64 core. It generates per-cycle stall and bubble controls for the F/D/E/M/W pipeline registers and the set_cc enable, covering load/use, mispredicted JXX, RET and exception hazards. It also runs a run/freeze/stop FSM with a debug freeze handshake and saturating hazard performance counters. It sits beside decode/forwarding and drives the pipeline-register enables.

Parameters:
CNT_W, 32, width of each performance counter
DRAIN_CYCLES, 3, cycles of E-bubbling after freeze entry before freeze_ack_o asserts (empties E/M/W)

Ports:
clk_i  input  1  clock
rst_i  input  1  synchronous active-high reset
D_icode_i  input  4  icode in D register
E_icode_i  input  4  icode in E register
M_icode_i  input  4  icode in M register
E_dstM_i  input  4  dstM in E register (0xF = none)
d_srcA_i  input  4  decode srcA
d_srcB_i  input  4  decode srcB
e_Cnd_i  input  1  execute condition result
m_stat_i  input  3  memory-stage status (AOK=1, HLT=2, ADR=3, INS=4)
W_stat_i  input  3  W register status
freeze_req_i  input  1  debug freeze request, level
cnt_clr_i  input  1  synchronous clear of all counters
F_stall_o  output  1  hold F register
D_stall_o  output  1  hold D register
D_bubble_o  output  1  load NOP into D
E_bubble_o  output  1  load NOP into E
M_bubble_o  output  1  load NOP into M
W_stall_o  output  1  hold W register
set_cc_o  output  1  condition-code write enable
freeze_ack_o  output  1  pipeline frozen and drained (registered)
halted_o  output  1  STOPPED state reached (registered)
cyc_cnt_o  output  CNT_W  cycles spent in RUN
lu_cnt_o  output  CNT_W  load/use stall cycles
mispred_cnt_o  output  CNT_W  mispredict cycles
ret_cnt_o  output  CNT_W  RET stall cycles

Behaviour:
- Hazard terms (combinational): LU = E_icode in {MRMOVQ 5, POPQ B} and E_dstM_i != 0xF and E_dstM_i in {d_srcA_i, d_srcB_i}; MP = E_icode==JXX(7) and !e_Cnd_i; RT = RET(9) in any of D/E/M icode; XM = m_stat_i in {2,3,4}; XW = W_stat_i in {2,3,4}.
- RUN: F_stall=LU|RT; D_stall=LU; D_bubble=MP|(RT&!LU); E_bubble=MP|LU; M_bubble=XM|XW; W_stall=XW; set_cc=(E_icode==OPQ 6)&!XM&!XW.
- Outputs combinational from inputs plus registered state; zero added latency.
- FSM states RUN, DRAIN, FROZEN, STOPPED; reset -> RUN, drain counter 0.
- RUN: XW -> STOPPED (highest priority); else freeze_req_i & !LU & !MP & !RT -> DRAIN with cnt=0; freeze_req_i with any hazard active stays in RUN until hazards clear.
- DRAIN: F_stall=D_stall=E_bubble=1, other hazard outputs as in RUN (M_bubble/W_stall still follow XM/XW), set_cc as RUN. XW -> STOPPED; !freeze_req_i -> RUN; cnt==DRAIN_CYCLES-1 -> FROZEN; else cnt+1.
- FROZEN: same controls as DRAIN; freeze_ack_o=1. !freeze_req_i -> RUN; ack drops on the same edge.
- STOPPED: F_stall=D_stall=W_stall=1, D/E/M_bubble=1, set_cc=0, halted_o=1; exit only by reset; freeze_req_i ignored, freeze_ack_o=0.
- During rst_i=1: F/D/W_stall=0, D/E/M_bubble=1, set_cc=0. Registered outputs reset to 0 on the next edge. Reset mid-DRAIN/FROZEN/STOPPED returns to RUN.
- Counters increment only in RUN, saturate at all-ones with no wrap, and clear on rst_i or cnt_clr_i. cnt_clr_i wins over an increment in the same cycle.
- lu_cnt increments on LU; mispred_cnt on MP; ret_cnt on RT&!LU; cyc_cnt every RUN cycle.

Test Plan:
- E_icode=5, E_dstM=3, d_srcA=3 in RUN -> F_stall=D_stall=E_bubble=1, D_bubble=0, lu_cnt +1 per cycle; E_dstM=0xF -> no stall.
- E_icode=7, e_Cnd=0 -> D_bubble=E_bubble=1, F_stall=0, mispred_cnt=1 after 1 cycle; with e_Cnd=1 -> all 0.
- RET walks D->E->M over 3 cycles -> F_stall=1 and D_bubble=1 each cycle, ret_cnt=3. LU and RT together -> D_stall=1, D_bubble=0.
- freeze_req_i=1 with no hazards -> freeze_ack_o=1 on edge 4, E_bubble=1 throughout. Deassert -> ack=0 next edge, controls as RUN. Request during MP -> DRAIN entry delayed until MP clears.
- W_stat=3 -> halted_o=1 next edge, all stall/bubble outputs 1, set_cc=0, counters frozen. rst_i -> RUN, halted_o=0.
- Force lu_cnt to 2^CNT_W-1 (CNT_W=4 build: hold LU 20 cycles) -> counter holds 15. cnt_clr_i with LU=1 -> counter reads 0.
